// File: rtl/multigate_pkg.sv
// -----------------------------------------------------------------------------
// multigate_pkg
//   Shared types and elaboration-time helpers for the pipelined reduction gate.
//   - op_t          : per-beat reduction operator (AND / OR / XOR / XNOR)
//   - identity()    : padding value that leaves a group's result unchanged
//   - combine()     : two-input step of the reduction (XNOR reduces as XOR)
//   - num_stages()  : tree depth, ceil(log_fanin(width))
//   - node_count()  : number of partial results present at a given tree level
//   - level_offset(): bit offset of a level inside the flattened level bus
// -----------------------------------------------------------------------------
package multigate_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_t;

  // AND is neutral under 1; OR/XOR are neutral under 0. XNOR is carried as XOR
  // through the tree and inverted once at the end, so it pads with 0 as well.
  function automatic logic identity(input op_t op);
    return (op == OP_AND);
  endfunction

  function automatic logic combine(input op_t op, input logic a, input logic b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int num_stages(input int width, input int fanin);
    int n;
    int st;
    n  = width;
    st = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 1) begin
        n  = (n + fanin - 1) / fanin;
        st = st + 1;
      end
    end
    return st;
  endfunction

  // Level 0 is the raw bus; level num_stages() holds the single result bit.
  function automatic int node_count(input int width, input int fanin, input int level);
    int n;
    n = width;
    for (int i = 0; i < level; i++) begin
      n = (n + fanin - 1) / fanin;
    end
    return n;
  endfunction

  function automatic int level_offset(input int width, input int fanin, input int level);
    int off;
    off = 0;
    for (int i = 0; i < level; i++) begin
      off = off + node_count(width, fanin, i);
    end
    return off;
  endfunction

endpackage

// File: rtl/multigate_reduce_stage.sv
// -----------------------------------------------------------------------------
// multigate_reduce_stage
//   One level of the reduction tree. Groups IN_W partials into FANIN-wide
//   nodes (padding the last group with the operator identity), reduces each
//   group, and registers {valid, op, partial} behind a valid/ready handshake.
//
//   Parameters: IN_W  partials entering this level
//               FANIN inputs per node
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     in_valid/in_ready   upstream handshake (in_ready is combinational)
//     in_op, in_data      operator and partials of the incoming beat
//     out_valid/out_ready downstream handshake
//     out_op, out_data    registered operator and reduced partials
// -----------------------------------------------------------------------------
module multigate_reduce_stage
  import multigate_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int FANIN = 4,
  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              in_op,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output op_t              out_op,
  output logic [OUT_W-1:0] out_data
);

  localparam int PAD_W = OUT_W * FANIN;

  logic [PAD_W-1:0] w_padded;
  logic [OUT_W-1:0] w_next;

  logic             r_valid;
  op_t              r_op;
  logic [OUT_W-1:0] r_data;

  // This level can take a new beat when it is empty or its beat leaves now.
  assign in_ready = !r_valid || out_ready;

  // NOTE: combinational logic uses blocking '=' with a default for every
  // output assigned first, so no path leaves a value held (no latch).
  always_comb begin
    logic w_acc;
    w_next   = '0;
    w_padded = {PAD_W{identity(in_op)}};
    w_padded[IN_W-1:0] = in_data;
    for (int g = 0; g < OUT_W; g++) begin
      w_acc = w_padded[g*FANIN];
      for (int j = 1; j < FANIN; j++) begin
        w_acc = combine(in_op, w_acc, w_padded[g*FANIN + j]);
      end
      w_next[g] = w_acc;
    end
  end

  // NOTE: registers use non-blocking '<=' so every stage samples the values
  // its neighbour held before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_op    <= OP_AND;
      r_data  <= '0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_op   <= in_op;
        r_data <= w_next;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_op    = r_op;
  assign out_data  = r_data;

endmodule

// File: rtl/multigate_reduce_pipe.sv
// -----------------------------------------------------------------------------
// multigate_reduce_pipe
//   Pipelined WIDTH-input reduction gate with a per-beat operator
//   (AND/OR/XOR/XNOR) built from a FANIN-ary tree, one register per level,
//   elastic valid/ready on both sides.
//
//   Parameters: WIDTH (>=2) bus width, FANIN (2..8) inputs per node.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     in_valid/in_ready   input handshake
//     bus [WIDTH-1:0]     operand bits
//     op  [1:0]           00 AND, 01 OR, 10 XOR, 11 XNOR
//     out_valid/out_ready output handshake
//     s                   reduction result
//
//   Build option MULTIGATE_SKID_EN: adds a 2-entry skid buffer ahead of the
//   tree so in_ready comes from a register (latency +1, capacity +2).
//   Without it in_ready is combinational from the out_ready chain.
// -----------------------------------------------------------------------------
module multigate_reduce_pipe
  import multigate_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FANIN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] bus,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s
);

  localparam int STAGES   = num_stages(WIDTH, FANIN);
  localparam int DATA_W   = level_offset(WIDTH, FANIN, STAGES + 1);
  localparam int LAST_OFF = level_offset(WIDTH, FANIN, STAGES);

  // All tree levels share one flat bus; level k occupies
  // [level_offset(k) +: node_count(k)], so every bit has exactly one driver.
  logic [STAGES:0]   w_lvl_valid;
  logic [STAGES:0]   w_lvl_ready;
  op_t               w_lvl_op [STAGES+1];
  logic [DATA_W-1:0] w_lvl_data;

`ifdef MULTIGATE_SKID_EN
  logic [WIDTH-1:0] r_skid_bus [2];
  op_t              r_skid_op  [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;
  logic             r_in_ready;
  logic [1:0]       w_cnt_next;
  logic             w_push;
  logic             w_pop;

  assign w_push     = in_valid && r_in_ready;
  assign w_pop      = (r_cnt != 2'd0) && w_lvl_ready[0];
  assign w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      // Ready for the next cycle is decided from next occupancy only, which
      // breaks the out_ready -> in_ready combinational path.
      r_in_ready <= (w_cnt_next != 2'd2);
    end
  end

  // NOTE: the skid entries are storage, not state: they are not reset because
  // r_cnt alone says whether an entry holds a live beat.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_skid_bus[r_wr_ptr] <= bus;
      r_skid_op[r_wr_ptr]  <= op_t'(op);
    end
  end

  assign in_ready              = r_in_ready;
  assign w_lvl_valid[0]        = (r_cnt != 2'd0);
  assign w_lvl_op[0]           = r_skid_op[r_rd_ptr];
  assign w_lvl_data[WIDTH-1:0] = r_skid_bus[r_rd_ptr];
`else
  assign in_ready              = w_lvl_ready[0];
  assign w_lvl_valid[0]        = in_valid;
  assign w_lvl_op[0]           = op_t'(op);
  assign w_lvl_data[WIDTH-1:0] = bus;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    localparam int IN_W    = node_count(WIDTH, FANIN, k);
    localparam int OUT_W   = node_count(WIDTH, FANIN, k + 1);
    localparam int IN_OFF  = level_offset(WIDTH, FANIN, k);
    localparam int OUT_OFF = level_offset(WIDTH, FANIN, k + 1);

    multigate_reduce_stage #(
      .IN_W  (IN_W),
      .FANIN (FANIN)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w_lvl_valid[k]),
      .in_ready  (w_lvl_ready[k]),
      .in_op     (w_lvl_op[k]),
      .in_data   (w_lvl_data[IN_OFF +: IN_W]),
      .out_valid (w_lvl_valid[k+1]),
      .out_ready (w_lvl_ready[k+1]),
      .out_op    (w_lvl_op[k+1]),
      .out_data  (w_lvl_data[OUT_OFF +: OUT_W])
    );
  end

  assign w_lvl_ready[STAGES] = out_ready;
  assign out_valid           = w_lvl_valid[STAGES];

  // XNOR travels as XOR; the single inversion happens here. The last stage
  // resets to op AND with data 0, so s reads 0 out of reset.
  assign s = w_lvl_data[LAST_OFF] ^ (w_lvl_op[STAGES] == OP_XNOR);

endmodule

// File: tb/tb_multigate_reduce_pipe.sv
// -----------------------------------------------------------------------------
// tb_multigate_reduce_pipe
//   Directed bench for multigate_reduce_pipe. DUT a: WIDTH=16, FANIN=4.
//   DUT b: WIDTH=5, FANIN=4 (identity padding of partial groups).
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_multigate_reduce_pipe;

`ifdef MULTIGATE_SKID_EN
  localparam int LAT       = 3;
  localparam int STALL_ACC = 3;
`else
  localparam int LAT       = 2;
  localparam int STALL_ACC = 2;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bus;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic        s;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [4:0]  b_bus;
  logic [1:0]  b_op;
  logic        b_out_valid;
  logic        b_out_ready;
  logic        b_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] st_bus [4];
  logic [1:0]  st_op  [4];
  logic        st_exp [4];

  multigate_reduce_pipe #(.WIDTH(16), .FANIN(4)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bus       (bus),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s)
  );

  multigate_reduce_pipe #(.WIDTH(5), .FANIN(4)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .bus       (b_bus),
    .op        (b_op),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .s         (b_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated beat: checks acceptance, latency and result.
  task automatic single(input bit use_b, input logic [15:0] b, input logic [1:0] o,
                        input logic exp, input string tag);
    int lat;
    @(negedge clk);
    if (use_b) begin
      b_in_valid = 1'b1; b_bus = b[4:0]; b_op = o;
    end else begin
      in_valid = 1'b1; bus = b; op = o;
    end
    #1 check({tag, "_in_ready"}, use_b ? b_in_ready : in_ready, 1'b1);
    @(negedge clk);
    in_valid   = 1'b0;
    b_in_valid = 1'b0;
    lat = 1;
    while (!(use_b ? b_out_valid : out_valid) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_valid"}, use_b ? b_out_valid : out_valid, 1'b1);
    check({tag, "_s"}, use_b ? b_s : s, exp);
  endtask

  // Streams st_* beats back to back with out_ready low for stall_len cycles
  // starting at cycle stall_from; checks every emitted result in order.
  task automatic run_stream(input int stall_from, input int stall_len,
                            output int first_emit, output int last_emit,
                            output int acc_in_stall, output int in_ready_c2);
    int sent;
    int got;
    sent = 0; got = 0; first_emit = -1; last_emit = -1;
    acc_in_stall = 0; in_ready_c2 = -1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      out_ready = !(c >= stall_from && c < stall_from + stall_len);
      if (sent < 4) begin
        in_valid = 1'b1; bus = st_bus[sent]; op = st_op[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) in_ready_c2 = int'(in_ready);
      if (out_valid && out_ready) begin
        check($sformatf("stream_s%0d", got), s, st_exp[got]);
        if (got == 0) first_emit = c;
        last_emit = c;
        got++;
      end
      if (in_valid && in_ready) begin
        if (!out_ready) acc_in_stall++;
        sent++;
      end
    end
    check("stream_count", got, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int first_emit;
    int last_emit;
    int acc_stall;
    int rdy_c2;
    int stale;

    reset = 1'b1;
    in_valid = 1'b0; bus = '0; op = 2'b00; out_ready = 1'b1;
    b_in_valid = 1'b0; b_bus = '0; b_op = 2'b00; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_b_out_valid", b_out_valid, 1'b0);

    // AND across all ones, then with bit 0 cleared.
    single(1'b0, 16'hFFFF, 2'b00, 1'b1, "and_ffff");
    single(1'b0, 16'hFFFE, 2'b00, 1'b0, "and_fffe");
    single(1'b0, 16'hFFFF, 2'b10, 1'b0, "xor_ffff");
    single(1'b0, 16'h0000, 2'b11, 1'b1, "xnor_0000");

    // Back-to-back stream, no stall: one result per cycle.
    st_bus[0] = 16'h0000; st_op[0] = 2'b01; st_exp[0] = 1'b0;
    st_bus[1] = 16'h0100; st_op[1] = 2'b01; st_exp[1] = 1'b1;
    st_bus[2] = 16'h0007; st_op[2] = 2'b10; st_exp[2] = 1'b1;
    st_bus[3] = 16'h0007; st_op[3] = 2'b11; st_exp[3] = 1'b0;
    run_stream(0, 0, first_emit, last_emit, acc_stall, rdy_c2);
    check("b2b_first", first_emit, LAT);
    check("b2b_span", last_emit - first_emit, 3);

    // Stream with out_ready low for the first 3 cycles.
    st_bus[0] = 16'hFFFF; st_op[0] = 2'b00; st_exp[0] = 1'b1;
    st_bus[1] = 16'h0000; st_op[1] = 2'b01; st_exp[1] = 1'b0;
    st_bus[2] = 16'h0001; st_op[2] = 2'b10; st_exp[2] = 1'b1;
    st_bus[3] = 16'h0001; st_op[3] = 2'b11; st_exp[3] = 1'b0;
    run_stream(0, 3, first_emit, last_emit, acc_stall, rdy_c2);
    check("stall_accepted", acc_stall, STALL_ACC);
`ifndef MULTIGATE_SKID_EN
    check("stall_in_ready_c2", rdy_c2, 0);
`endif
    check("stall_first", first_emit, 3);
    check("stall_last", last_emit, 6);

    // Reset with two beats in flight: nothing may come out afterwards.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; bus = 16'hFFFF; op = 2'b00;
    @(negedge clk);
    bus = 16'hFFFF; op = 2'b01;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_s", s, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_stale", stale, 0);

    // WIDTH=5: last groups are padded with the operator identity.
    single(1'b1, 16'h001F, 2'b00, 1'b1, "w5_and_1f");
    single(1'b1, 16'h000F, 2'b00, 1'b0, "w5_and_0f");
    single(1'b1, 16'h0010, 2'b01, 1'b1, "w5_or_10");
    single(1'b1, 16'h0010, 2'b10, 1'b1, "w5_xor_10");
    single(1'b1, 16'h0010, 2'b11, 1'b0, "w5_xnor_10");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
